// File: rtl/fma_sequencer_pkg.sv
// Shared types and defaults for the FMA command sequencer.
package fma_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LEN_W_DEFAULT = 8;

endpackage

// File: rtl/fma_sequencer_if.sv
// Command, operand-stream and result handshakes of the FMA sequencer.
interface fma_sequencer_if
    import fma_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = LEN_W_DEFAULT
);
    localparam int SCALE_W = $clog2(WIDTH);

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [LEN_W-1:0]          cmd_len;
    logic [SCALE_W-1:0]        cmd_scale;
    logic signed [WIDTH-1:0]   cmd_seed;

    logic                      op_valid;
    logic                      op_ready;
    logic signed [WIDTH-1:0]   op_a;
    logic signed [WIDTH-1:0]   op_b;

    logic                      res_valid;
    logic                      res_ready;
    logic signed [WIDTH-1:0]   res_data;

    modport master (
        output cmd_valid, cmd_len, cmd_scale, cmd_seed,
        input  cmd_ready,
        output op_valid, op_a, op_b,
        input  op_ready,
        input  res_valid, res_data,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_scale, cmd_seed,
        output cmd_ready,
        input  op_valid, op_a, op_b,
        output op_ready,
        output res_valid, res_data,
        input  res_ready
    );

endinterface

// File: rtl/fma_sequencer.sv
// Sequences dot-product commands through an external FMA unit.
// Optional FMA_SEQ_PIPELINE_EN: accept the next command in the result-handshake cycle.
module fma_sequencer
    import fma_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    fma_sequencer_if.slave              bus,
    output logic signed [WIDTH-1:0]     fma_a,
    output logic signed [WIDTH-1:0]     fma_b,
    output logic [$clog2(WIDTH)-1:0]    fma_scale,
    output logic signed [WIDTH-1:0]     fma_seed,
    output logic                        fma_update_acc,
    output logic                        fma_en,
    input  logic signed [WIDTH-1:0]     fma_acc_out
);

    localparam int SCALE_W = $clog2(WIDTH);

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        cnt_q;
    logic [SCALE_W-1:0]      scale_q;
    logic signed [WIDTH-1:0] seed_q;
    logic signed [WIDTH-1:0] res_q;
    logic                    first_q;

    logic cmd_ready_c;
    logic op_ready_c;
    logic res_valid_c;
    logic beat;
    logic cmd_fire;

    assign cmd_fire = bus.cmd_valid && cmd_ready_c;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d        = state_q;
        cmd_ready_c    = 1'b0;
        op_ready_c     = 1'b0;
        res_valid_c    = 1'b0;
        beat           = 1'b0;
        fma_update_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid)
                    state_d = (bus.cmd_len == '0) ? DONE : RUN;
            end
            RUN: begin
                op_ready_c     = 1'b1;
                beat           = bus.op_valid;
                fma_update_acc = beat && first_q;
                if (beat && cnt_q == LEN_W'(1))
                    state_d = DONE;
            end
            DONE: begin
                res_valid_c = 1'b1;
`ifdef FMA_SEQ_PIPELINE_EN
                cmd_ready_c = bus.res_ready;
                if (bus.res_ready) begin
                    if (bus.cmd_valid)
                        state_d = (bus.cmd_len == '0) ? DONE : RUN;
                    else
                        state_d = IDLE;
                end
`else
                cmd_ready_c = 1'b0;
                if (bus.res_ready)
                    state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            scale_q <= '0;
            seed_q  <= '0;
            res_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cmd_fire) begin
                cnt_q   <= bus.cmd_len;
                scale_q <= bus.cmd_scale;
                seed_q  <= bus.cmd_seed;
                first_q <= 1'b1;
                // A zero-length command reports its seed without touching the FMA.
                if (bus.cmd_len == '0)
                    res_q <= bus.cmd_seed;
            end else if (beat) begin
                cnt_q   <= cnt_q - LEN_W'(1);
                first_q <= 1'b0;
                if (cnt_q == LEN_W'(1))
                    res_q <= fma_acc_out;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.op_ready  = op_ready_c;
    assign bus.res_valid = res_valid_c;
    assign bus.res_data  = res_q;

    assign fma_a     = bus.op_a;
    assign fma_b     = bus.op_b;
    assign fma_scale = scale_q;
    assign fma_seed  = seed_q;
    assign fma_en    = beat;

endmodule
